// File: rtl/program_counter_pkg.sv
// rtl/program_counter_pkg.sv - shared defaults for the program counter slice
package program_counter_pkg;

    // Default counter width and reset value used when the top is not overridden
    localparam int PC_WIDTH_DEFAULT = 16;
    localparam int PC_RESET_DEFAULT = 0;

endpackage : program_counter_pkg

// File: rtl/program_counter_gates.sv
// rtl/program_counter_gates.sv - gate primitives and per-bit 2:1 mux
module Not (
    input  logic i_a,
    output logic o_y
);
    assign o_y = ~i_a;
endmodule : Not

module Nand (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = ~(i_a & i_b);
endmodule : Nand

module And (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    logic w_nand;

    // And is an inverted Nand so the library has a single two-input base cell
    Nand u_nand (.i_a(i_a), .i_b(i_b), .o_y(w_nand));
    Not  u_not  (.i_a(w_nand), .o_y(o_y));
endmodule : And

module Or (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a | i_b;
endmodule : Or

module Xor (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a ^ i_b;
endmodule : Xor

module mux2 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_s,
    output logic o_y
);
    logic w_s_n;
    logic w_a_term;
    logic w_b_term;

    // y = (a & ~s) | (b & s); i_a is passed through when the select is low
    Not u_not  (.i_a(i_s), .o_y(w_s_n));
    And u_and_a (.i_a(i_a), .i_b(w_s_n), .o_y(w_a_term));
    And u_and_b (.i_a(i_b), .i_b(i_s), .o_y(w_b_term));
    Or  u_or   (.i_a(w_a_term), .i_b(w_b_term), .o_y(o_y));
endmodule : mux2

// File: rtl/program_counter_incrementer.sv
// rtl/program_counter_incrementer.sv - ripple +1 chain of half adders
module incrementer #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry_out
);
    logic [WIDTH:0] w_carry;

    // Carry-in is fixed at one; callers decide whether the sum is used
    assign w_carry[0] = 1'b1;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_half_adder
            Xor u_sum   (.i_a(i_in[i]), .i_b(w_carry[i]), .o_y(o_sum[i]));
            And u_carry (.i_a(i_in[i]), .i_b(w_carry[i]), .o_y(w_carry[i+1]));
        end
    endgenerate

    // MSB carry is high only when the input was all ones
    assign o_carry_out = w_carry[WIDTH];
endmodule : incrementer

// File: rtl/program_counter.sv
// rtl/program_counter.sv - loadable incrementing program counter with wrap pulse
module program_counter
    import program_counter_pkg::*;
#(
    parameter int               WIDTH       = PC_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] out,
    output logic             wrap
);
    logic [WIDTH-1:0] r_out;
    logic             r_wrap;

    logic [WIDTH-1:0] w_sum;
    logic             w_carry_out;
    logic [WIDTH-1:0] w_inc_or_hold;
    logic [WIDTH-1:0] w_next;
    logic             w_load_n;
    logic             w_inc_selected;
    logic             w_wrap_next;

    incrementer #(.WIDTH(WIDTH)) u_incrementer (
        .i_in        (r_out),
        .o_sum       (w_sum),
        .o_carry_out (w_carry_out)
    );

    // First level picks increment over hold, second level lets load override both
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_next_mux
            mux2 u_inc_mux (
                .i_a (r_out[i]),
                .i_b (w_sum[i]),
                .i_s (inc),
                .o_y (w_inc_or_hold[i])
            );
            mux2 u_load_mux (
                .i_a (w_inc_or_hold[i]),
                .i_b (in[i]),
                .i_s (load),
                .o_y (w_next[i])
            );
        end
    endgenerate

    // Wrap is only meaningful when the increment path actually reaches the register
    Not u_load_inv   (.i_a(load), .o_y(w_load_n));
    And u_inc_sel    (.i_a(inc), .i_b(w_load_n), .o_y(w_inc_selected));
    And u_wrap_gate  (.i_a(w_carry_out), .i_b(w_inc_selected), .o_y(w_wrap_next));

    // State register; reset overrides whatever the mux tree selected
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out  <= RESET_VALUE;
            r_wrap <= 1'b0;
        end else begin
            r_out  <= w_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign out  = r_out;
    assign wrap = r_wrap;
endmodule : program_counter

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - directed and reference-model checks of program_counter
module tb_program_counter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset16, load16, inc16;
    logic [15:0] in16;
    logic [15:0] out16;
    logic        wrap16;

    logic        reset4, load4, inc4;
    logic [3:0]  in4;
    logic [3:0]  out4;
    logic        wrap4;

    program_counter #(.WIDTH(16), .RESET_VALUE(16'h0000)) u_pc16 (
        .clk   (clk),
        .reset (reset16),
        .in    (in16),
        .load  (load16),
        .inc   (inc16),
        .out   (out16),
        .wrap  (wrap16)
    );

    program_counter #(.WIDTH(4), .RESET_VALUE(4'hA)) u_pc4 (
        .clk   (clk),
        .reset (reset4),
        .in    (in4),
        .load  (load4),
        .inc   (inc4),
        .out   (out4),
        .wrap  (wrap4)
    );

    typedef struct {
        string       name;
        logic        reset;
        logic        load;
        logic        inc;
        logic [15:0] in;
        logic [15:0] exp_out;
        logic        exp_wrap;
    } vec_t;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step16(input logic r, input logic l, input logic i, input logic [15:0] d);
        reset16 = r;
        load16  = l;
        inc16   = i;
        in16    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step4(input logic r, input logic l, input logic i, input logic [3:0] d);
        reset4 = r;
        load4  = l;
        inc4   = i;
        in4    = d;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        logic [3:0] m_out;
        logic       m_wrap;
        logic       r, l, i;
        logic [3:0] d;

        reset16 = 1'b0; load16 = 1'b0; inc16 = 1'b0; in16 = '0;
        reset4  = 1'b0; load4  = 1'b0; inc4  = 1'b0; in4  = '0;

        //              name            rst  ld   inc  in        out       wrap
        vecs.push_back('{"reset_prio",  1'b1,1'b1,1'b1,16'h1234, 16'h0000, 1'b0});
        vecs.push_back('{"inc_1",       1'b0,1'b0,1'b1,16'h0000, 16'h0001, 1'b0});
        vecs.push_back('{"inc_2",       1'b0,1'b0,1'b1,16'h0000, 16'h0002, 1'b0});
        vecs.push_back('{"inc_3",       1'b0,1'b0,1'b1,16'h0000, 16'h0003, 1'b0});
        vecs.push_back('{"hold_1",      1'b0,1'b0,1'b0,16'h5555, 16'h0003, 1'b0});
        vecs.push_back('{"hold_2",      1'b0,1'b0,1'b0,16'h5555, 16'h0003, 1'b0});
        vecs.push_back('{"load_prio",   1'b0,1'b1,1'b1,16'hBEEF, 16'hBEEF, 1'b0});
        vecs.push_back('{"inc_after_ld",1'b0,1'b0,1'b1,16'h0000, 16'hBEF0, 1'b0});
        vecs.push_back('{"load_ffff",   1'b0,1'b1,1'b0,16'hFFFF, 16'hFFFF, 1'b0});
        vecs.push_back('{"wrap",        1'b0,1'b0,1'b1,16'h0000, 16'h0000, 1'b1});
        vecs.push_back('{"post_wrap",   1'b0,1'b0,1'b1,16'h0000, 16'h0001, 1'b0});
        vecs.push_back('{"ld_a4",       1'b0,1'b1,1'b0,16'h00A4, 16'h00A4, 1'b0});
        vecs.push_back('{"count_a5",    1'b0,1'b0,1'b1,16'h0000, 16'h00A5, 1'b0});
        vecs.push_back('{"reset_mid",   1'b1,1'b0,1'b1,16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{"after_reset", 1'b0,1'b0,1'b1,16'h0000, 16'h0001, 1'b0});
        vecs.push_back('{"ld_inc_ffff", 1'b0,1'b1,1'b1,16'hFFFF, 16'hFFFF, 1'b0});
        vecs.push_back('{"ld_beats_wrap",1'b0,1'b1,1'b1,16'h1000,16'h1000, 1'b0});
        vecs.push_back('{"ld_ffff_b",   1'b0,1'b1,1'b0,16'hFFFF, 16'hFFFF, 1'b0});
        vecs.push_back('{"rst_beats_wrap",1'b1,1'b0,1'b1,16'h0000,16'h0000,1'b0});
        vecs.push_back('{"ld_ffff_c",   1'b0,1'b1,1'b0,16'hFFFF, 16'hFFFF, 1'b0});
        vecs.push_back('{"wrap_2",      1'b0,1'b0,1'b1,16'h0000, 16'h0000, 1'b1});
        vecs.push_back('{"wrap_drops",  1'b0,1'b0,1'b0,16'h0000, 16'h0000, 1'b0});

        foreach (vecs[k]) begin
            step16(vecs[k].reset, vecs[k].load, vecs[k].inc, vecs[k].in);
            check({vecs[k].name, ".out"},  32'(out16),  32'(vecs[k].exp_out));
            check({vecs[k].name, ".wrap"}, 32'(wrap16), 32'(vecs[k].exp_wrap));
        end

        // Narrow instance: non-zero reset value and wrap from 4'hF
        step4(1'b1, 1'b0, 1'b0, 4'h0);
        check("w4_reset.out", 32'(out4), 32'h0000_000A);
        check("w4_reset.wrap", 32'(wrap4), 32'h0);
        for (int n = 1; n <= 5; n++) begin
            step4(1'b0, 1'b0, 1'b1, 4'h0);
            check("w4_inc.out", 32'(out4), 32'(4'hA + n));
            check("w4_inc.wrap", 32'(wrap4), 32'h0);
        end
        step4(1'b0, 1'b0, 1'b1, 4'h0);
        check("w4_wrap.out", 32'(out4), 32'h0);
        check("w4_wrap.wrap", 32'(wrap4), 32'h1);
        step4(1'b0, 1'b0, 1'b1, 4'h0);
        check("w4_after.out", 32'(out4), 32'h1);
        check("w4_after.wrap", 32'(wrap4), 32'h0);

        // Random stream against a behavioural reference, starting from a known reset
        step4(1'b1, 1'b0, 1'b0, 4'h0);
        m_out  = 4'hA;
        m_wrap = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            r = ($urandom_range(0, 19) == 0);
            l = ($urandom_range(0, 5) == 0);
            i = ($urandom_range(0, 3) != 0);
            d = 4'($urandom_range(0, 15));
            if (r) begin
                m_out  = 4'hA;
                m_wrap = 1'b0;
            end else if (l) begin
                m_out  = d;
                m_wrap = 1'b0;
            end else if (i) begin
                m_wrap = (m_out == 4'hF);
                m_out  = m_out + 4'h1;
            end else begin
                m_wrap = 1'b0;
            end
            step4(r, l, i, d);
            check("w4_rand.out", 32'(out4), 32'(m_out));
            check("w4_rand.wrap", 32'(wrap4), 32'(m_wrap));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_program_counter
